// File: rtl/config_pkg.sv
// -----------------------------------------------------------------------------
// config_pkg
// Shared configuration for the functional-unit DDR port and its responder.
//   DdrDataWidth / DdrAddressWidth : word and word-address widths
//   ddr_address_t / ddr_data_t     : address and data word types
//   DdrResponderDefaultDepth       : default responder storage depth (words)
//   host_fsm_state_t               : responder host-port FSM states
//   ddr_addr_in_range()            : true when an address indexes real storage
// -----------------------------------------------------------------------------
package config_pkg;

    localparam int DdrDataWidth    = 32;
    localparam int DdrAddressWidth = 32;

    typedef logic [DdrAddressWidth-1:0] ddr_address_t;
    typedef logic [DdrDataWidth-1:0]    ddr_data_t;

    localparam int DdrResponderDefaultDepth = 256;

    typedef enum logic {
        HOST_IDLE = 1'b0,
        HOST_RSP  = 1'b1
    } host_fsm_state_t;

    // Depth is a power of two, so an address is in range exactly when every
    // bit above the index field is zero.
    function automatic logic ddr_addr_in_range(ddr_address_t addr, int unsigned idx_w);
        return (addr >> idx_w) == '0;
    endfunction

endpackage

// File: rtl/ddr_read_pipe.sv
// -----------------------------------------------------------------------------
// ddr_read_pipe
// N-stage delay line for an FU read: strobe plus the word fetched at issue.
// Latency = 0 is a pure pass-through.
//   clk_i, rst_ni : clock, asynchronous active-low reset (clears all stages)
//   valid_i       : read strobe at issue
//   data_i        : word fetched from storage in the issue cycle
//   valid_o       : strobe delayed by Latency cycles
//   data_o        : delayed word, forced to 0 whenever valid_o is low
// -----------------------------------------------------------------------------
module ddr_read_pipe #(
    parameter int Latency   = 0,
    parameter int DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 valid_i,
    input  logic [DataWidth-1:0] data_i,
    output logic                 valid_o,
    output logic [DataWidth-1:0] data_o
);

    generate
        if (Latency == 0) begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = clk_i ^ rst_ni;
            assign valid_o = valid_i;
            assign data_o  = valid_i ? data_i : '0;
        end else begin : g_pipe
            // The word is captured at issue time rather than re-read at the
            // end of the pipe, so a read always returns the contents as they
            // were in its issue cycle (old word on a same-cycle collision).
            logic [Latency-1:0] valid_q;
            logic [DataWidth-1:0] data_q [Latency];

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    valid_q <= '0;
                    for (int i = 0; i < Latency; i++) begin
                        data_q[i] <= '0;
                    end
                end else begin
                    valid_q[0] <= valid_i;
                    data_q[0]  <= valid_i ? data_i : '0;
                    for (int i = 1; i < Latency; i++) begin
                        valid_q[i] <= valid_q[i-1];
                        data_q[i]  <= data_q[i-1];
                    end
                end
            end

            assign valid_o = valid_q[Latency-1];
            assign data_o  = valid_q[Latency-1] ? data_q[Latency-1] : '0;
        end
    endgenerate

endmodule

// File: rtl/ddr_responder.sv
// -----------------------------------------------------------------------------
// ddr_responder
// Responder end of the FU DDR port: word-addressed on-chip storage serving the
// load/store unit's write and read ports, plus a host valid/ready port used to
// preload and dump memory. The FU always has priority; host requests are only
// accepted in cycles with no FU activity.
//
// Handshake: a host request transfers on a cycle where host_req_valid_i and
// host_req_ready_o are both high; a host response transfers on a cycle where
// host_rsp_valid_o and host_rsp_ready_i are both high. Valid and payload are
// held stable by the source until the transfer.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   ddr_w_address_i/en_i/data_i   FU write port (commits at the rising edge)
//   ddr_r_address_i/en_i          FU read request
//   ddr_r_data_o, ddr_r_valid_o   FU read data after ReadLatency cycles
//   host_req_*                    host request (we=1 write, we=0 read)
//   host_rsp_*                    host read response
//   range_err_o                   sticky out-of-range flag (optional)
//
// Optional feature macro: DDR_RESPONDER_RANGE_CHECK_EN
//   Adds range_err_o; out-of-range writes are dropped, out-of-range reads
//   return 0. Without it, addresses wrap modulo Depth.
// -----------------------------------------------------------------------------
module ddr_responder
    import config_pkg::*;
#(
    parameter int Depth       = DdrResponderDefaultDepth,
    parameter int ReadLatency = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [DdrAddressWidth-1:0] ddr_w_address_i,
    input  logic                    ddr_w_en_i,
    input  logic [DdrDataWidth-1:0] ddr_w_data_i,
    input  logic [DdrAddressWidth-1:0] ddr_r_address_i,
    input  logic                    ddr_r_en_i,
    output logic [DdrDataWidth-1:0] ddr_r_data_o,
    output logic                    ddr_r_valid_o,
    input  logic                    host_req_valid_i,
    output logic                    host_req_ready_o,
    input  logic                    host_req_we_i,
    input  logic [DdrAddressWidth-1:0] host_req_address_i,
    input  logic [DdrDataWidth-1:0] host_req_wdata_i,
    output logic                    host_rsp_valid_o,
    input  logic                    host_rsp_ready_i,
`ifdef DDR_RESPONDER_RANGE_CHECK_EN
    output logic [DdrDataWidth-1:0] host_rsp_rdata_o,
    output logic                    range_err_o
`else
    output logic [DdrDataWidth-1:0] host_rsp_rdata_o
`endif
);

    localparam int IdxW = $clog2(Depth);

    // Storage is deliberately not reset: preloaded contents survive rst_ni.
    ddr_data_t mem_q [Depth];

    host_fsm_state_t state_q, state_d;
    ddr_data_t       rsp_data_q, rsp_data_d;

    logic [IdxW-1:0] w_idx, r_idx, h_idx;
    logic            w_ok, r_ok, h_ok;
    logic            host_accept;
    logic            fu_wr, host_wr;
    ddr_data_t       fu_rd_word;
    ddr_data_t       host_rd_word;

    assign w_idx = ddr_w_address_i[IdxW-1:0];
    assign r_idx = ddr_r_address_i[IdxW-1:0];
    assign h_idx = host_req_address_i[IdxW-1:0];

`ifdef DDR_RESPONDER_RANGE_CHECK_EN
    logic range_err_q;
    logic range_hit;

    assign w_ok = ddr_addr_in_range(ddr_w_address_i, IdxW);
    assign r_ok = ddr_addr_in_range(ddr_r_address_i, IdxW);
    assign h_ok = ddr_addr_in_range(host_req_address_i, IdxW);

    assign range_hit = (ddr_w_en_i & !w_ok) | (ddr_r_en_i & !r_ok) | (host_accept & !h_ok);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            range_err_q <= 1'b0;
        end else if (range_hit) begin
            range_err_q <= 1'b1;
        end
    end

    assign range_err_o = range_err_q;

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!range_hit)
                else $error("ddr_responder: address out of range (Depth=%0d)", Depth);
        end
    end
`endif
`else
    // Upper address bits are ignored: addresses wrap modulo Depth.
    logic unused_upper_addr;
    assign unused_upper_addr = ^{ddr_w_address_i, ddr_r_address_i, host_req_address_i};
    assign w_ok = 1'b1;
    assign r_ok = 1'b1;
    assign h_ok = 1'b1;
`endif

    // Ready drops whenever the FU touches the port, so a host write and an FU
    // write can never commit in the same cycle.
    assign host_req_ready_o = (state_q == HOST_IDLE) & !ddr_r_en_i & !ddr_w_en_i;
    assign host_accept      = host_req_valid_i & host_req_ready_o;

    assign fu_wr   = ddr_w_en_i & w_ok;
    assign host_wr = host_accept & host_req_we_i & h_ok;

    always_ff @(posedge clk_i) begin
        if (fu_wr) begin
            mem_q[w_idx] <= ddr_w_data_i;
        end else if (host_wr) begin
            mem_q[h_idx] <= host_req_wdata_i;
        end
    end

    // Combinational fetch sees the pre-edge contents, giving old-word
    // semantics on a same-cycle read/write collision.
    assign fu_rd_word   = (ddr_r_en_i & r_ok) ? mem_q[r_idx] : '0;
    assign host_rd_word = h_ok ? mem_q[h_idx] : '0;

    ddr_read_pipe #(
        .Latency   (ReadLatency),
        .DataWidth (DdrDataWidth)
    ) u_read_pipe (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (ddr_r_en_i),
        .data_i  (fu_rd_word),
        .valid_o (ddr_r_valid_o),
        .data_o  (ddr_r_data_o)
    );

    always_comb begin
        state_d    = state_q;
        rsp_data_d = rsp_data_q;
        unique case (state_q)
            HOST_IDLE: begin
                if (host_accept && !host_req_we_i) begin
                    state_d    = HOST_RSP;
                    rsp_data_d = host_rd_word;
                end
            end
            HOST_RSP: begin
                // Returning to idle takes a cycle, so no request can be
                // accepted in the response handshake cycle.
                if (host_rsp_ready_i) begin
                    state_d = HOST_IDLE;
                end
            end
            default: state_d = HOST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= HOST_IDLE;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign host_rsp_valid_o = (state_q == HOST_RSP);
    assign host_rsp_rdata_o = rsp_data_q;

endmodule

// File: tb/tb_ddr_responder.sv
// -----------------------------------------------------------------------------
// tb_ddr_responder
// Two responders share every input: dut0 with ReadLatency=0 and dut2 with
// ReadLatency=2. Inputs are driven just after the falling edge and outputs
// are sampled 1 ns later; the rising edge commits.
// -----------------------------------------------------------------------------
module tb_ddr_responder;

    localparam int Depth = 256;

    logic        clk;
    logic        rst_n;
    logic [31:0] w_addr, r_addr, h_addr;
    logic        w_en, r_en, h_valid, h_we, h_rsp_ready;
    logic [31:0] w_data, h_wdata;

    logic [31:0] r_data0, r_data2, rsp_data0, rsp_data2;
    logic        r_valid0, r_valid2, h_ready0, h_ready2, rsp_valid0, rsp_valid2;
`ifdef DDR_RESPONDER_RANGE_CHECK_EN
    logic        range_err0, range_err2;
`endif

    int checks = 0;
    int errors = 0;

    // Reference memory: one word per index, address taken modulo Depth.
    logic [31:0] ref_mem [Depth];
    // Expected FU read output of the latency-2 instance: {valid, data}.
    logic [32:0] exp_q[$];

    ddr_responder #(.Depth(Depth), .ReadLatency(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .ddr_w_address_i(w_addr), .ddr_w_en_i(w_en), .ddr_w_data_i(w_data),
        .ddr_r_address_i(r_addr), .ddr_r_en_i(r_en),
        .ddr_r_data_o(r_data0), .ddr_r_valid_o(r_valid0),
        .host_req_valid_i(h_valid), .host_req_ready_o(h_ready0),
        .host_req_we_i(h_we), .host_req_address_i(h_addr),
        .host_req_wdata_i(h_wdata),
        .host_rsp_valid_o(rsp_valid0), .host_rsp_ready_i(h_rsp_ready),
`ifdef DDR_RESPONDER_RANGE_CHECK_EN
        .range_err_o(range_err0),
`endif
        .host_rsp_rdata_o(rsp_data0)
    );

    ddr_responder #(.Depth(Depth), .ReadLatency(2)) dut2 (
        .clk_i(clk), .rst_ni(rst_n),
        .ddr_w_address_i(w_addr), .ddr_w_en_i(w_en), .ddr_w_data_i(w_data),
        .ddr_r_address_i(r_addr), .ddr_r_en_i(r_en),
        .ddr_r_data_o(r_data2), .ddr_r_valid_o(r_valid2),
        .host_req_valid_i(h_valid), .host_req_ready_o(h_ready2),
        .host_req_we_i(h_we), .host_req_address_i(h_addr),
        .host_req_wdata_i(h_wdata),
        .host_rsp_valid_o(rsp_valid2), .host_rsp_ready_i(h_rsp_ready),
`ifdef DDR_RESPONDER_RANGE_CHECK_EN
        .range_err_o(range_err2),
`endif
        .host_rsp_rdata_o(rsp_data2)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        w_en = 0; w_addr = 0; w_data = 0;
        r_en = 0; r_addr = 0;
        h_valid = 0; h_we = 0; h_addr = 0; h_wdata = 0;
        h_rsp_ready = 0;
    endtask

    // Start a new cycle: move to the falling edge and drop all strobes.
    task automatic begin_cycle();
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1;
        idle_inputs();
        #2 rst_n = 0;
        #1;
        checks++;
        if ({r_valid0, r_data0, r_valid2, r_data2, rsp_valid0, rsp_data0, rsp_valid2, rsp_data2} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rv0=%b rd0=%h rv2=%b rd2=%h hv=%b hd=%h required all 0",
                     r_valid0, r_data0, r_valid2, r_data2, rsp_valid0, rsp_data0);
        end
        @(negedge clk);
        rst_n = 1;
        settle();
        checks++;
        if (h_ready0 !== 1'b1 || h_ready2 !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b/%b required 1", h_ready0, h_ready2);
        end
    endtask

    task automatic test_preload();
        // Host write addr 3
        begin_cycle();
        h_valid = 1; h_we = 1; h_addr = 3; h_wdata = 32'hA5A5_0001;
        settle();
        checks++;
        if (h_ready0 !== 1'b1) begin
            errors++; $display("FAIL preload_wr_ready: got %b required 1", h_ready0);
        end
        ref_mem[3] = 32'hA5A5_0001;
        // Host read addr 3
        begin_cycle();
        h_valid = 1; h_we = 0; h_addr = 3;
        settle();
        checks++;
        if (rsp_valid0 !== 1'b0 || h_ready0 !== 1'b1) begin
            errors++; $display("FAIL preload_rd_accept: rsp_valid=%b ready=%b required 0/1", rsp_valid0, h_ready0);
        end
        // Response held for 3 cycles with rsp_ready low; ready low while pending.
        for (int i = 0; i < 3; i++) begin
            begin_cycle();
            h_valid = 1; h_we = 1; h_addr = 9; h_wdata = 32'hDEAD_BEEF;
            settle();
            checks++;
            if (rsp_valid0 !== 1'b1 || rsp_data0 !== ref_mem[3] || h_ready0 !== 1'b0) begin
                errors++;
                $display("FAIL preload_rsp_hold%0d: valid=%b data=%h ready=%b required 1/%h/0",
                         i, rsp_valid0, rsp_data0, h_ready0, ref_mem[3]);
            end
        end
        begin_cycle();
        h_rsp_ready = 1;
        settle();
        checks++;
        if (rsp_valid0 !== 1'b1 || h_ready0 !== 1'b0) begin
            errors++; $display("FAIL preload_rsp_handshake: valid=%b ready=%b required 1/0", rsp_valid0, h_ready0);
        end
        begin_cycle();
        settle();
        checks++;
        if (rsp_valid0 !== 1'b0 || h_ready0 !== 1'b1) begin
            errors++; $display("FAIL preload_rsp_clear: valid=%b ready=%b required 0/1", rsp_valid0, h_ready0);
        end
    endtask

    task automatic test_fu_burst();
        for (int i = 0; i < 4; i++) begin
            begin_cycle();
            w_en = 1; w_addr = 10 + i; w_data = i + 1;
            ref_mem[10 + i] = i + 1;
        end
        for (int i = 0; i < 4; i++) begin
            begin_cycle();
            r_en = 1; r_addr = 10 + i;
            settle();
            checks++;
            if (r_valid0 !== 1'b1 || r_data0 !== 32'(i + 1)) begin
                errors++;
                $display("FAIL burst_rd%0d: valid=%b data=%h required 1/%h", i, r_valid0, r_data0, i + 1);
            end
        end
    endtask

    task automatic test_latency2();
        logic [32:0] exp;
        // Drain anything in flight, then seed two empty pipe slots.
        begin_cycle(); begin_cycle();
        exp_q.delete();
        exp_q.push_back(33'h0);
        exp_q.push_back(33'h0);
        for (int c = 0; c < 6; c++) begin
            begin_cycle();
            if (c < 3) begin
                r_en = 1; r_addr = 10 + c;
                exp_q.push_back({1'b1, ref_mem[10 + c]});
            end else begin
                exp_q.push_back(33'h0);
            end
            settle();
            exp = exp_q.pop_front();
            checks++;
            if ({r_valid2, r_data2} !== exp) begin
                errors++;
                $display("FAIL lat2_cycle%0d: valid=%b data=%h required %b/%h",
                         c, r_valid2, r_data2, exp[32], exp[31:0]);
            end
        end
    endtask

    task automatic test_collision();
        begin_cycle();
        w_en = 1; w_addr = 5; w_data = 32'h11;
        ref_mem[5] = 32'h11;
        begin_cycle();
        w_en = 1; w_addr = 5; w_data = 32'h22;
        r_en = 1; r_addr = 5;
        settle();
        checks++;
        if (r_data0 !== ref_mem[5]) begin
            errors++; $display("FAIL collision_old: data=%h required %h", r_data0, ref_mem[5]);
        end
        ref_mem[5] = 32'h22;
        begin_cycle();
        r_en = 1; r_addr = 5;
        settle();
        checks++;
        if (r_data0 !== ref_mem[5]) begin
            errors++; $display("FAIL collision_new: data=%h required %h", r_data0, ref_mem[5]);
        end
    endtask

    task automatic test_priority();
        logic [31:0] hv;
        hv = $urandom;
        for (int i = 0; i < 4; i++) begin
            begin_cycle();
            h_valid = 1; h_we = 1; h_addr = 7; h_wdata = hv;
            w_en = 1; w_addr = 32 + i; w_data = $urandom;
            settle();
            checks++;
            if (h_ready0 !== 1'b0) begin
                errors++; $display("FAIL priority_block%0d: ready=%b required 0", i, h_ready0);
            end
            ref_mem[32 + i] = w_data;
        end
        begin_cycle();
        h_valid = 1; h_we = 1; h_addr = 7; h_wdata = hv;
        settle();
        checks++;
        if (h_ready0 !== 1'b1) begin
            errors++; $display("FAIL priority_accept: ready=%b required 1", h_ready0);
        end
        ref_mem[7] = hv;
        begin_cycle();
        r_en = 1; r_addr = 7;
        settle();
        checks++;
        if (r_data0 !== hv) begin
            errors++; $display("FAIL priority_data: data=%h required %h", r_data0, hv);
        end
    endtask

    // Random FU/host traffic; index 3 is left alone for the reset test.
    task automatic test_random();
        logic [32:0] exp;
        logic [31:0] exp0;
        logic        exp_ready;
        int          idx;
        // Fill every word so every random read has a defined answer.
        for (int i = 0; i < Depth; i++) begin
            if (i != 3) begin
                begin_cycle();
                w_en = 1; w_addr = i; w_data = $urandom;
                ref_mem[i] = w_data;
            end
        end
        begin_cycle(); begin_cycle();
        exp_q.delete();
        exp_q.push_back(33'h0);
        exp_q.push_back(33'h0);
        for (int c = 0; c < 200; c++) begin
            begin_cycle();
            w_en = ($urandom_range(0, 2) == 0);
            do idx = $urandom_range(0, Depth - 1); while (idx == 3);
            w_addr = idx + Depth * $urandom_range(0, 3);
            w_data = $urandom;
            r_en = ($urandom_range(0, 1) == 1);
            r_addr = $urandom_range(0, 4 * Depth - 1);
            if (r_addr % Depth == 3) r_addr = r_addr + 1;
            h_valid = ($urandom_range(0, 2) == 0);
            h_we = 1;
            do idx = $urandom_range(0, Depth - 1); while (idx == 3);
            h_addr = idx + Depth * $urandom_range(0, 3);
            h_wdata = $urandom;

            exp0 = r_en ? ref_mem[r_addr % Depth] : 32'h0;
            exp_ready = !r_en && !w_en;
            exp_q.push_back({r_en, exp0});
            settle();
            exp = exp_q.pop_front();
            checks++;
            if (r_valid0 !== r_en || r_data0 !== exp0) begin
                errors++;
                $display("FAIL rand_lat0_c%0d: valid=%b data=%h required %b/%h", c, r_valid0, r_data0, r_en, exp0);
            end
            checks++;
            if ({r_valid2, r_data2} !== exp) begin
                errors++;
                $display("FAIL rand_lat2_c%0d: valid=%b data=%h required %b/%h", c, r_valid2, r_data2, exp[32], exp[31:0]);
            end
            checks++;
            if (h_ready0 !== exp_ready) begin
                errors++;
                $display("FAIL rand_ready_c%0d: ready=%b required %b", c, h_ready0, exp_ready);
            end
            if (w_en) ref_mem[w_addr % Depth] = w_data;
            else if (h_valid && exp_ready) ref_mem[h_addr % Depth] = h_wdata;
        end
    endtask

    task automatic test_reset_mid();
        begin_cycle();
        h_valid = 1; h_we = 0; h_addr = 3;
        begin_cycle();
        r_en = 1; r_addr = 10;
        settle();
        checks++;
        if (rsp_valid0 !== 1'b1) begin
            errors++; $display("FAIL rstmid_pending: valid=%b required 1", rsp_valid0);
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if (rsp_valid0 !== 1'b0 || rsp_data0 !== 32'h0 || r_valid2 !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_drop: rsp_valid=%b rsp_data=%h rv2=%b required 0/0/0", rsp_valid0, rsp_data0, r_valid2);
        end
        @(negedge clk);
        idle_inputs();
        rst_n = 1;
        begin_cycle();
        settle();
        checks++;
        if (r_valid2 !== 1'b0) begin
            errors++; $display("FAIL rstmid_pipe_flushed: rv2=%b required 0", r_valid2);
        end
        begin_cycle();
        h_valid = 1; h_we = 0; h_addr = 3;
        begin_cycle();
        h_rsp_ready = 1;
        settle();
        checks++;
        if (rsp_valid0 !== 1'b1 || rsp_data0 !== 32'hA5A5_0001) begin
            errors++;
            $display("FAIL rstmid_mem_kept: valid=%b data=%h required 1/a5a50001", rsp_valid0, rsp_data0);
        end
        begin_cycle();
    endtask

`ifdef DDR_RESPONDER_RANGE_CHECK_EN
    task automatic test_range();
        do_reset();
        settle();
        checks++;
        if (range_err0 !== 1'b0) begin
            errors++; $display("FAIL range_reset: err=%b required 0", range_err0);
        end
        begin_cycle();
        w_en = 1; w_addr = Depth + 1; w_data = ~ref_mem[1];
        begin_cycle();
        r_en = 1; r_addr = 1;
        settle();
        checks++;
        if (range_err0 !== 1'b1 || r_data0 !== ref_mem[1]) begin
            errors++;
            $display("FAIL range_write: err=%b data=%h required 1/%h", range_err0, r_data0, ref_mem[1]);
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_preload();
        test_fu_burst();
        test_latency2();
        test_collision();
        test_priority();
        test_random();
        test_reset_mid();
`ifdef DDR_RESPONDER_RANGE_CHECK_EN
        test_range();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
